// File: rtl/qdec_cabac_pkg.sv
// Shared CABAC context constants and the context arbiter state encoding.
package qdec_cabac_pkg;

    localparam int CTX_ADDR_W = 10;
    localparam int CTX_DATA_W = 8;
    localparam int NUM_CTX    = 1024;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        INIT = 2'd1,
        DONE = 2'd2,
        RUN  = 2'd3
    } ctx_arb_state_e;

endpackage

// File: rtl/qdec_ctx_arbiter.sv
// Owner of the single-port context RAM: runs the slice-start init walk,
// then arbitrates decoder reads against post-bin updates, forwarding
// same-address update data so a read never returns a stale state.
module qdec_ctx_arbiter #(
    parameter int ADDR_W  = qdec_cabac_pkg::CTX_ADDR_W,
    parameter int DATA_W  = qdec_cabac_pkg::CTX_DATA_W,
    parameter int NUM_CTX = qdec_cabac_pkg::NUM_CTX,
    parameter int STALL_W = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               init_start,
    input  logic [DATA_W-1:0]  init_wdata,
    input  logic               init_wvld,
    output logic               init_wrdy,
    output logic [ADDR_W-1:0]  init_idx,
    output logic               init_done,
    output logic               busy,
    input  logic [ADDR_W-1:0]  rd_addr,
    input  logic               rd_vld,
    output logic               rd_rdy,
    output logic [DATA_W-1:0]  rd_data,
    output logic               rd_data_vld,
    input  logic [ADDR_W-1:0]  upd_addr,
    input  logic [DATA_W-1:0]  upd_data,
    input  logic               upd_vld,
    output logic               upd_rdy,
    output logic [ADDR_W-1:0]  ctx_addr,
    output logic [DATA_W-1:0]  ctx_wdata,
    input  logic [DATA_W-1:0]  ctx_rdata,
    output logic               ctx_we,
    output logic               ctx_en,
    output logic [STALL_W-1:0] stall_cnt
);
    import qdec_cabac_pkg::*;

    ctx_arb_state_e     state;
    logic [ADDR_W-1:0]  initIdx;
    logic [STALL_W-1:0] stallCnt;
    logic               rdDataVld;
    logic               bypSel;
    logic [DATA_W-1:0]  bypData;
    logic [DATA_W-1:0]  heldData;
    logic [DATA_W-1:0]  rdMux;
    logic               initAcc;
    logic               updAcc;
    logic               rdAcc;
    logic               lastIdx;
    logic               stallInc;

    // Accept decisions: init_start pre-empts everything; in RUN an update
    // wins the RAM port and only a same-address read may ride along on it.
    always_comb begin
        initAcc = 1'b0;
        updAcc  = 1'b0;
        rdAcc   = 1'b0;
        if (!init_start) begin
            case (state)
                INIT:    initAcc = init_wvld;
                RUN: begin
                    updAcc = upd_vld;
                    rdAcc  = rd_vld && (!upd_vld || rd_addr == upd_addr);
                end
                default: ;
            endcase
        end
    end

    assign lastIdx  = (initIdx == ADDR_W'(NUM_CTX - 1));
    assign stallInc = (state == RUN) && rd_vld && !rdAcc && (stallCnt != '1);

    assign init_wrdy = initAcc;
    assign init_idx  = initIdx;
    assign init_done = (state == DONE);
    assign busy      = (state == INIT) || (state == DONE);
    assign rd_rdy    = rdAcc;
    assign upd_rdy   = updAcc;
    assign stall_cnt = stallCnt;

    // A bypassed read costs no RAM cycle: the update write owns the port.
    assign ctx_we    = initAcc || updAcc;
    assign ctx_en    = ctx_we || rdAcc;
    assign ctx_addr  = initAcc ? initIdx : updAcc ? upd_addr : rdAcc ? rd_addr : '0;
    assign ctx_wdata = initAcc ? init_wdata : updAcc ? upd_data : '0;

    assign rdMux       = bypSel ? bypData : ctx_rdata;
    assign rd_data     = rdDataVld ? rdMux : heldData;
    assign rd_data_vld = rdDataVld;

    // Control FSM and init address walk.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            initIdx <= '0;
        end else if (init_start) begin
            state   <= INIT;
            initIdx <= '0;
        end else begin
            case (state)
                INIT: if (initAcc) begin
                    initIdx <= initIdx + 1'b1;
                    if (lastIdx) state <= DONE;
                end
                DONE: begin
                    state   <= RUN;
                    initIdx <= '0;
                end
                default: ;
            endcase
        end
    end

    // Read return path: registered valid, bypass select/data, and a hold
    // register so rd_data stays put while the RAM output wanders.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdDataVld <= 1'b0;
            bypSel    <= 1'b0;
            bypData   <= '0;
            heldData  <= '0;
        end else begin
            rdDataVld <= rdAcc;
            if (rdAcc)          bypSel   <= updAcc;
            if (rdAcc && updAcc) bypData <= upd_data;
            if (rdDataVld)      heldData <= rdMux;
        end
    end

    // Saturating count of RUN cycles where a read was held off.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)           stallCnt <= '0;
        else if (stallInc) stallCnt <= stallCnt + 1'b1;
    end

endmodule
